// File: rtl/scan_dump_controller.sv
// Scan-chain host master: dumps the chain as packed words (loopback, non-destructive)
// or loads it from a word stream, LSB of word 0 first.
module scan_dump_controller #(
    parameter int unsigned CHAIN_LEN  = 2056,
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = $clog2(CHAIN_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    input  logic                  cmd_mode,
    output logic                  cmd_ready,
    output logic                  scan_enable,
    output logic                  scan_in,
    input  logic                  scan_out,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned BP_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(CHAIN_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] ALL_BITS = CNT_WIDTH'(CHAIN_LEN);
    localparam logic [BP_W-1:0]      LAST_POS = BP_W'(WORD_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DUMP,
        ST_LOAD,
        ST_FIN
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [BP_W-1:0]       bitpos_q, bitpos_d;
    logic [WORD_WIDTH-1:0] acc_q, acc_d;
    logic [WORD_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic [WORD_WIDTH-1:0] buf_q, buf_d;
    logic                  buf_full_q, buf_full_d;

    logic                  last_bit;
    logic                  word_end;
    logic                  shift;
    logic                  scan_in_c;
    logic                  in_ready_c;
    logic [WORD_WIDTH-1:0] acc_next;

    assign last_bit = (cnt_q == LAST_BIT);
    assign word_end = (bitpos_q == LAST_POS) || last_bit;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bitpos_d    = bitpos_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        shift       = 1'b0;
        scan_in_c   = 1'b0;
        in_ready_c  = 1'b0;
        acc_next    = acc_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d     = cmd_mode ? ST_LOAD : ST_DUMP;
                    cnt_d       = '0;
                    bitpos_d    = '0;
                    acc_d       = '0;
                    out_valid_d = 1'b0;
                    buf_full_d  = 1'b0;
                end
            end

            ST_DUMP: begin
                // Hold off the word-completing shift while the previous word is still unaccepted.
                shift     = (cnt_q != ALL_BITS) && !(word_end && out_valid_q && !out_ready);
                scan_in_c = shift & scan_out;
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
                if (shift) begin
                    acc_next[bitpos_q] = scan_out;
                    if (word_end) begin
                        out_data_d  = acc_next;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                    end else begin
                        acc_d = acc_next;
                    end
                end
                if (out_valid_q && out_ready && (cnt_q == ALL_BITS)) begin
                    state_d = ST_FIN;
                end
            end

            ST_LOAD: begin
                shift      = buf_full_q;
                scan_in_c  = buf_full_q & buf_q[bitpos_q];
                // Refill is allowed on the buffer's final bit, except after the chain's last bit.
                in_ready_c = !buf_full_q || (word_end && !last_bit);
                if (shift && word_end) begin
                    buf_full_d = 1'b0;
                end
                if (in_valid && in_ready_c) begin
                    buf_d      = in_data;
                    buf_full_d = 1'b1;
                end
                if (shift && last_bit) begin
                    state_d = ST_FIN;
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (shift) begin
            cnt_d    = cnt_q + 1'b1;
            bitpos_d = word_end ? '0 : bitpos_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bitpos_q    <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bitpos_q    <= bitpos_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_FIN);
    assign scan_enable = shift;
    assign scan_in     = scan_in_c;
    assign in_ready    = in_ready_c;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;

endmodule
